// File: rtl/ripple_operand_sequencer_if.sv
// Byte-stream, operand, flag and result signals between the operand sequencer
// and its surroundings (byte producer, ripple comparison circuit, result consumer).
interface ripple_operand_sequencer_if #(
   parameter int WIDTH = 32
);
   logic [7:0]       in_byte;
   logic             in_byte_valid;
   logic             out_byte_ready;
   logic [WIDTH-1:0] out_a;
   logic [WIDTH-1:0] out_b;
   logic             in_q1;
   logic             in_q2;
   logic             out_res_q1;
   logic             out_res_q2;
   logic             out_res_valid;
   logic             in_res_ready;
   logic             out_busy;

   modport master (
      output in_byte, in_byte_valid, in_q1, in_q2, in_res_ready,
      input  out_byte_ready, out_a, out_b, out_res_q1, out_res_q2, out_res_valid, out_busy
   );

   modport slave (
      input  in_byte, in_byte_valid, in_q1, in_q2, in_res_ready,
      output out_byte_ready, out_a, out_b, out_res_q1, out_res_q2, out_res_valid, out_busy
   );
endinterface

// File: rtl/ripple_operand_sequencer.sv
// Loads operands A and B byte-wise, holds them while the external ripple
// comparator settles, then captures its two flags onto a valid/ready result port.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_LOAD_A | accepting bytes of operand A (little-endian)
// ST_LOAD_B | accepting bytes of operand B
// ST_SETTLE | operands held; down-counter runs until terminal count
// ST_RESULT | captured flags presented, waiting for consumer handshake
module ripple_operand_sequencer #(
   parameter int WIDTH         = 32,
   parameter int SETTLE_CYCLES = 4
) (
   input logic                       clk,
   input logic                       rst_n,
   ripple_operand_sequencer_if.slave bus
);
   localparam int             BYTES       = WIDTH / 8;
   localparam int             IDX_W       = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BYTES - 1);
   localparam logic [7:0]     SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_LOAD_A = 2'd0,
      ST_LOAD_B = 2'd1,
      ST_SETTLE = 2'd2,
      ST_RESULT = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q;
   logic [7:0]       cnt_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic             res_q1_q, res_q2_q, res_valid_q;
   logic             live_q;
   logic             byte_ready;
   logic             busy;
   logic             byte_acc;
   logic             last_byte;

   assign byte_acc  = bus.in_byte_valid & byte_ready;
   assign last_byte = (idx_q == LAST_IDX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_LOAD_A;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_LOAD_A: if (byte_acc && last_byte) state_d = ST_LOAD_B;
         ST_LOAD_B: if (byte_acc && last_byte) state_d = ST_SETTLE;
         ST_SETTLE: if (cnt_q == 8'd0)         state_d = ST_RESULT;
         ST_RESULT: if (bus.in_res_ready)      state_d = ST_LOAD_A;
         default:                              state_d = ST_LOAD_A;
      endcase
   end

   // live_q keeps byte_ready low for the single cycle following a reset edge.
   always_comb begin
      byte_ready = 1'b0;
      busy       = 1'b1;
      if (live_q && (state_q == ST_LOAD_A || state_q == ST_LOAD_B)) byte_ready = 1'b1;
      if (state_q == ST_LOAD_A && idx_q == '0)                       busy       = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q       <= '0;
         cnt_q       <= 8'd0;
         a_q         <= '0;
         b_q         <= '0;
         res_q1_q    <= 1'b0;
         res_q2_q    <= 1'b0;
         res_valid_q <= 1'b0;
         live_q      <= 1'b0;
      end else begin
         live_q <= 1'b1;
         if (byte_acc) begin
            if (state_q == ST_LOAD_A) a_q[8*idx_q +: 8] <= bus.in_byte;
            else                      b_q[8*idx_q +: 8] <= bus.in_byte;
            idx_q <= last_byte ? '0 : idx_q + 1'b1;
            if (last_byte && state_q == ST_LOAD_B) cnt_q <= SETTLE_INIT;
         end
         if (state_q == ST_SETTLE) begin
            if (cnt_q == 8'd0) begin
               res_q1_q    <= bus.in_q1;
               res_q2_q    <= bus.in_q2;
               res_valid_q <= 1'b1;
            end else begin
               cnt_q <= cnt_q - 8'd1;
            end
         end
         if (state_q == ST_RESULT && bus.in_res_ready) res_valid_q <= 1'b0;
      end
   end

   assign bus.out_byte_ready = byte_ready;
   assign bus.out_busy       = busy;
   assign bus.out_a          = a_q;
   assign bus.out_b          = b_q;
   assign bus.out_res_q1     = res_q1_q;
   assign bus.out_res_q2     = res_q2_q;
   assign bus.out_res_valid  = res_valid_q;
endmodule

// File: tb/tb_ripple_operand_sequencer.sv
// Self-checking bench: comparator stub on out_a/out_b, byte-level operand model,
// result expectations computed from the loaded operand values.
module tb_ripple_operand_sequencer;
   localparam int WIDTH  = 32;
   localparam int SETTLE = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   tests = 0;
   int   fails = 0;

   logic [31:0] exp_a = '0, exp_b = '0;
   logic        exp_q1 = 1'b0, exp_q2 = 1'b0;
   logic        glitch_en = 1'b0, glitch_val = 1'b0;

   ripple_operand_sequencer_if #(.WIDTH(WIDTH)) bus ();

   ripple_operand_sequencer #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   assign bus.in_q1 = (bus.out_a > bus.out_b);
   assign bus.in_q2 = glitch_en ? glitch_val : (bus.out_a == bus.out_b);

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offers the 8 bytes of (a,b); a byte counts as taken only when ready was high.
   task automatic load_pair(input logic [31:0] a, input logic [31:0] b, input bit sparse,
                            output int cycles);
      logic [7:0] bytes [8];
      int k;
      for (int i = 0; i < 4; i++) begin
         bytes[i]   = a[8*i +: 8];
         bytes[4+i] = b[8*i +: 8];
      end
      k = 0;
      cycles = 0;
      while (k < 8 && cycles < 200) begin
         if (sparse && (cycles % 2 == 1)) begin
            bus.in_byte_valid = 1'b0;
            bus.in_byte       = 8'($urandom);
         end else begin
            bus.in_byte_valid = 1'b1;
            bus.in_byte       = bytes[k];
         end
         if (bus.in_byte_valid && bus.out_byte_ready) begin
            if (k < 4) exp_a[8*k +: 8] = bus.in_byte;
            else       exp_b[8*(k-4) +: 8] = bus.in_byte;
            k++;
         end
         step();
         cycles++;
      end
      bus.in_byte_valid = 1'b0;
      tests++;
      if (k != 8) begin
         fails++;
         $display("FAIL load_timeout: accepted %0d bytes, required 8", k);
      end
   endtask

   task automatic wait_result(input bit glitch);
      int n;
      n = 0;
      while (bus.out_res_valid !== 1'b1 && n < 40) begin
         glitch_en  = glitch && (n < 2);
         glitch_val = n[0];
         step();
         n++;
      end
      glitch_en = 1'b0;
      exp_q1 = (exp_a > exp_b);
      exp_q2 = (exp_a == exp_b);
      tests++;
      if (n != SETTLE) begin
         fails++; $display("FAIL latency: got %0d edges, required %0d", n, SETTLE);
      end
      tests++;
      if (bus.out_a !== exp_a || bus.out_b !== exp_b) begin
         fails++; $display("FAIL operands: a=%h b=%h required a=%h b=%h", bus.out_a, bus.out_b, exp_a, exp_b);
      end
      tests++;
      if (bus.out_res_q1 !== exp_q1 || bus.out_res_q2 !== exp_q2) begin
         fails++; $display("FAIL flags: q1=%b q2=%b required q1=%b q2=%b", bus.out_res_q1, bus.out_res_q2, exp_q1, exp_q2);
      end
      tests++;
      if (bus.out_byte_ready !== 1'b0 || bus.out_busy !== 1'b1) begin
         fails++; $display("FAIL result_status: ready=%b busy=%b required 0/1", bus.out_byte_ready, bus.out_busy);
      end
   endtask

   task automatic release_result();
      bus.in_res_ready = 1'b1;
      step();
      bus.in_res_ready = 1'b0;
      tests++;
      if (bus.out_res_valid !== 1'b0 || bus.out_byte_ready !== 1'b1 || bus.out_busy !== 1'b0) begin
         fails++; $display("FAIL release: valid=%b ready=%b busy=%b required 0/1/0", bus.out_res_valid, bus.out_byte_ready, bus.out_busy);
      end
      tests++;
      if (bus.out_res_q1 !== exp_q1 || bus.out_res_q2 !== exp_q2) begin
         fails++; $display("FAIL flags_held: q1=%b q2=%b required q1=%b q2=%b", bus.out_res_q1, bus.out_res_q2, exp_q1, exp_q2);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_byte = 8'hA5;
      bus.in_byte_valid = 1'b1;
      bus.in_res_ready = 1'b0;
      repeat (3) step();
      tests++;
      if (bus.out_byte_ready !== 1'b0 || bus.out_busy !== 1'b0 || bus.out_res_valid !== 1'b0 ||
          bus.out_res_q1 !== 1'b0 || bus.out_res_q2 !== 1'b0 || bus.out_a !== '0 || bus.out_b !== '0) begin
         fails++; $display("FAIL reset_outputs: ready=%b busy=%b valid=%b a=%h b=%h required all 0",
                           bus.out_byte_ready, bus.out_busy, bus.out_res_valid, bus.out_a, bus.out_b);
      end
      rst_n = 1'b1;
      bus.in_byte_valid = 1'b0;
      step();
      tests++;
      if (bus.out_byte_ready !== 1'b1 || bus.out_busy !== 1'b0) begin
         fails++; $display("FAIL reset_release: ready=%b busy=%b required 1/0", bus.out_byte_ready, bus.out_busy);
      end
   endtask

   task automatic test_basic();
      int cyc;
      load_pair(32'h0000FFFF, 32'h0000F7DA, 1'b0, cyc);
      wait_result(1'b0);
      tests++;
      if (bus.out_a !== 32'h0000FFFF || bus.out_b !== 32'h0000F7DA || bus.out_res_q1 !== 1'b1 || bus.out_res_q2 !== 1'b0) begin
         fails++; $display("FAIL basic_values: a=%h b=%h q1=%b q2=%b required 0000ffff 0000f7da 1 0",
                           bus.out_a, bus.out_b, bus.out_res_q1, bus.out_res_q2);
      end
      release_result();
   endtask

   task automatic test_hold();
      int cyc;
      load_pair(32'd1, 32'd3, 1'b0, cyc);
      wait_result(1'b0);
      for (int i = 0; i < 10; i++) begin
         bus.in_byte_valid = 1'b1;
         bus.in_byte = 8'($urandom);
         step();
         tests++;
         if (bus.out_res_valid !== 1'b1 || bus.out_res_q1 !== 1'b0 || bus.out_res_q2 !== 1'b0 ||
             bus.out_byte_ready !== 1'b0 || bus.out_a !== 32'd1 || bus.out_b !== 32'd3) begin
            fails++; $display("FAIL hold_%0d: valid=%b q1=%b q2=%b ready=%b a=%h b=%h required 1 0 0 0 1 3",
                              i, bus.out_res_valid, bus.out_res_q1, bus.out_res_q2, bus.out_byte_ready, bus.out_a, bus.out_b);
         end
      end
      bus.in_byte_valid = 1'b0;
      release_result();
   endtask

   task automatic test_sparse_glitch();
      int cyc;
      load_pair(32'hDEADBEEF, 32'hDEADBEEF, 1'b1, cyc);
      wait_result(1'b1);
      tests++;
      if (bus.out_res_q2 !== 1'b1 || bus.out_res_q1 !== 1'b0) begin
         fails++; $display("FAIL glitch_capture: q1=%b q2=%b required 0 1", bus.out_res_q1, bus.out_res_q2);
      end
      release_result();
   endtask

   task automatic test_mid_reset();
      int cyc;
      bus.in_byte_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin bus.in_byte = 8'h11 * (i + 1); step(); end
      for (int i = 0; i < 2; i++) begin bus.in_byte = 8'h77; step(); end
      rst_n = 1'b0;
      step();
      tests++;
      if (bus.out_byte_ready !== 1'b0 || bus.out_busy !== 1'b0 || bus.out_res_valid !== 1'b0 ||
          bus.out_res_q1 !== 1'b0 || bus.out_res_q2 !== 1'b0 || bus.out_a !== '0 || bus.out_b !== '0) begin
         fails++; $display("FAIL midreset_outputs: ready=%b busy=%b valid=%b a=%h b=%h required all 0",
                           bus.out_byte_ready, bus.out_busy, bus.out_res_valid, bus.out_a, bus.out_b);
      end
      rst_n = 1'b1;
      bus.in_byte_valid = 1'b0;
      exp_a = '0; exp_b = '0; exp_q1 = 1'b0; exp_q2 = 1'b0;
      load_pair(32'h12345678, 32'h9ABCDEF0, 1'b0, cyc);
      wait_result(1'b0);
      release_result();
   endtask

   task automatic test_back_to_back();
      int cyc;
      bus.in_res_ready = 1'b1;
      load_pair(32'hCAFE0001, 32'hCAFE0002, 1'b0, cyc);
      wait_result(1'b0);
      step();
      tests++;
      if (bus.out_res_valid !== 1'b0 || bus.out_byte_ready !== 1'b1) begin
         fails++; $display("FAIL b2b_handshake1: valid=%b ready=%b required 0/1", bus.out_res_valid, bus.out_byte_ready);
      end
      load_pair(32'h80000000, 32'h7FFFFFFF, 1'b0, cyc);
      tests++;
      if (cyc != 8) begin
         fails++; $display("FAIL b2b_load_cycles: got %0d, required 8", cyc);
      end
      wait_result(1'b0);
      step();
      tests++;
      if (bus.out_res_valid !== 1'b0 || bus.out_byte_ready !== 1'b1) begin
         fails++; $display("FAIL b2b_handshake2: valid=%b ready=%b required 0/1", bus.out_res_valid, bus.out_byte_ready);
      end
      bus.in_res_ready = 1'b0;
   endtask

   task automatic test_random();
      int cyc;
      logic [31:0] a, b;
      for (int i = 0; i < 8; i++) begin
         a = $urandom;
         b = ($urandom_range(0, 2) == 0) ? a : 32'($urandom);
         load_pair(a, b, $urandom_range(0, 1) == 1, cyc);
         wait_result(1'b0);
         repeat ($urandom_range(0, 3)) step();
         release_result();
      end
   endtask

   initial begin
      bus.in_byte = 8'h00;
      bus.in_byte_valid = 1'b0;
      bus.in_res_ready = 1'b0;
      rst_n = 1'b0;
      test_reset();
      test_basic();
      test_hold();
      test_sparse_glitch();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
